switch_block_param: RTL and testbench

Parametrised successor to the fixed 4-track switch block. It routes TRACK_WIDTH tracks per side through 8-way output muxes, one per output track. Configuration uses a counted shift chain into a shadow register, then an explicit commit transfers shadow to active. Routing therefore never glitches mid-load, and short loads are detected. The block sits at every routing-channel intersection of the fabric; its config chain is daisy-chained with neighbouring tiles.

---
 rtl/switch_block_pkg.sv | 31 +++
 rtl/switch_mux8.sv | 18 +
 rtl/switch_block_param.sv | 155 +++++++++++++++
 tb/tb_switch_block_param.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_block_pkg.sv
// rtl/switch_block_pkg.sv - shared indices, mux code type and config FSM states for the switch block
// Contents:
//   NORTH/EAST/SOUTH/WEST            side indices into the side track arrays
//   NORTHWEST/NORTHEAST/...          corner indices into the corner input vector
//   sel_t, SEL_ZERO                  3-bit output mux code; SEL_ZERO drives a constant 0
//   cfg_state_t                      configuration load/commit state
package switch_block_pkg;

    localparam int NORTH = 0;
    localparam int EAST  = 1;
    localparam int SOUTH = 2;
    localparam int WEST  = 3;

    localparam int NORTHWEST = 0;
    localparam int NORTHEAST = 1;
    localparam int SOUTHEAST = 2;
    localparam int SOUTHWEST = 3;

    typedef logic [2:0] sel_t;

    // Code 1 would select the mux's own side, which is tied low instead
    localparam sel_t SEL_ZERO = 3'd1;

    typedef enum logic [1:0] {
        CFG_UNCONFIGURED,
        CFG_SHIFTING,
        CFG_LOADED,
        CFG_ACTIVE
    } cfg_state_t;

endpackage

// File: rtl/switch_mux8.sv
// rtl/switch_mux8.sv - combinational 8:1 track mux
// Ports:
//   sel      mux code selecting one of the eight sources
//   sources  candidate source bits, indexed by mux code
//   muxOut   selected source
module switch_mux8
    import switch_block_pkg::*;
(
    input  sel_t       sel,
    input  logic [7:0] sources,
    output logic       muxOut
);

    always_comb begin
        muxOut = sources[sel];
    end

endmodule

// File: rtl/switch_block_param.sv
// rtl/switch_block_param.sv - parametrised routing switch block with shadowed, committed configuration
// Optional feature macro: SWITCH_BLOCK_CFG_PARITY_EN (adds an even-parity bit at the chain tail)
// Ports:
//   i_ConfigClock        single clock for all logic
//   i_Reset              synchronous, active-high reset
//   i_ConfigShiftEnable  shift one config bit this cycle
//   i_ConfigShiftInput   serial config data in
//   o_ConfigShiftOutput  registered chain output to the next tile
//   i_ConfigCommit       request shadow -> active transfer
//   o_ConfigDone         active configuration is valid
//   o_ConfigError        sticky: commit attempted on an incomplete or corrupt load
//   i_SideInputs         [side][track] inputs, side N=0,E=1,S=2,W=3
//   o_SideOutputs        [side][track] outputs
//   i_CornerInputs       corner inputs NW=0,NE=1,SE=2,SW=3
module switch_block_param
    import switch_block_pkg::*;
#(
    parameter int TRACK_WIDTH = 4
) (
    input  logic                         i_ConfigClock,
    input  logic                         i_Reset,
    input  logic                         i_ConfigShiftEnable,
    input  logic                         i_ConfigShiftInput,
    output logic                         o_ConfigShiftOutput,
    input  logic                         i_ConfigCommit,
    output logic                         o_ConfigDone,
    output logic                         o_ConfigError,
    input  logic [3:0][TRACK_WIDTH-1:0]  i_SideInputs,
    output logic [3:0][TRACK_WIDTH-1:0]  o_SideOutputs,
    input  logic [3:0]                   i_CornerInputs
);

    localparam int CFG_BITS = 4 * TRACK_WIDTH * 3;
`ifdef SWITCH_BLOCK_CFG_PARITY_EN
    localparam int CHAIN_LEN = CFG_BITS + 1;
`else
    localparam int CHAIN_LEN = CFG_BITS;
`endif
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

    logic [CHAIN_LEN-1:0] shadowReg;
    logic [CFG_BITS-1:0]  activeReg;
    logic [CNT_W-1:0]     bitCount;
    logic [CNT_W-1:0]     nextCount;
    cfg_state_t           cfgState;

    logic [CFG_BITS-1:0]  shadowFields;
    logic                 loadComplete;
    logic                 parityOk;
    logic                 commitValid;

    // Routing fields sit above the optional parity bit, which is always shadow[0]
    assign shadowFields = shadowReg[CHAIN_LEN-1 -: CFG_BITS];
    assign loadComplete = (bitCount == CNT_FULL);

`ifdef SWITCH_BLOCK_CFG_PARITY_EN
    assign parityOk = ~^shadowReg;
`else
    assign parityOk = 1'b1;
`endif

    // Commit looks at the pre-shift shadow and count, even if a shift happens in the same cycle
    assign commitValid = i_ConfigCommit && loadComplete && parityOk;

    always_comb begin
        nextCount = bitCount;
        if (i_ConfigShiftEnable) begin
            if (commitValid) begin
                nextCount = CNT_W'(1);
            end else if (!loadComplete) begin
                nextCount = bitCount + 1'b1;
            end
        end else if (commitValid) begin
            nextCount = '0;
        end
    end

    always_ff @(posedge i_ConfigClock) begin
        if (i_Reset) begin
            shadowReg           <= '0;
            activeReg           <= {(4 * TRACK_WIDTH){SEL_ZERO}};
            bitCount            <= '0;
            cfgState            <= CFG_UNCONFIGURED;
            o_ConfigShiftOutput <= 1'b0;
            o_ConfigDone        <= 1'b0;
            o_ConfigError       <= 1'b0;
        end else begin
            bitCount <= nextCount;

            if (i_ConfigShiftEnable) begin
                shadowReg           <= {shadowReg[CHAIN_LEN-2:0], i_ConfigShiftInput};
                o_ConfigShiftOutput <= shadowReg[CHAIN_LEN-1];
            end

            if (i_ConfigCommit) begin
                if (commitValid) begin
                    activeReg     <= shadowFields;
                    o_ConfigDone  <= 1'b1;
                    o_ConfigError <= 1'b0;
                end else begin
                    o_ConfigError <= 1'b1;
                end
            end

            case (cfgState)
                CFG_UNCONFIGURED: begin
                    if (i_ConfigShiftEnable) begin
                        cfgState <= CFG_SHIFTING;
                    end
                end
                CFG_SHIFTING: begin
                    if (nextCount == CNT_FULL) begin
                        cfgState <= CFG_LOADED;
                    end
                end
                CFG_LOADED: begin
                    // A shift alongside the commit already starts the next load
                    if (commitValid) begin
                        cfgState <= i_ConfigShiftEnable ? CFG_SHIFTING : CFG_ACTIVE;
                    end
                end
                CFG_ACTIVE: begin
                    if (i_ConfigShiftEnable) begin
                        cfgState <= CFG_SHIFTING;
                    end
                end
                default: cfgState <= CFG_UNCONFIGURED;
            endcase
        end
    end

    // Code 2m selects corner (s+m)%4, code 2m+1 selects side (s+m)%4; own side (code 1) is tied low
    for (genvar s = 0; s < 4; s++) begin : g_side
        for (genvar t = 0; t < TRACK_WIDTH; t++) begin : g_track
            logic [7:0] muxSources;

            for (genvar m = 0; m < 4; m++) begin : g_src
                assign muxSources[2*m] = i_CornerInputs[(s + m) % 4];
                if (m == 0) begin : g_own
                    assign muxSources[1] = 1'b0;
                end else begin : g_other
                    assign muxSources[2*m+1] = i_SideInputs[(s + m) % 4][t];
                end
            end

            switch_mux8 u_mux (
                .sel     (sel_t'(activeReg[(s * TRACK_WIDTH + t) * 3 +: 3])),
                .sources (muxSources),
                .muxOut  (o_SideOutputs[s][t])
            );
        end
    end

endmodule

// File: tb/tb_switch_block_param.sv
// tb/tb_switch_block_param.sv - self-checking bench for switch_block_param
module tb_switch_block_param;

    localparam int W        = 4;
    localparam int CFG_BITS = 4 * W * 3;
`ifdef SWITCH_BLOCK_CFG_PARITY_EN
    localparam int CHAIN = CFG_BITS + 1;
`else
    localparam int CHAIN = CFG_BITS;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                shEn;
    logic                shIn;
    logic                shOut;
    logic                commit;
    logic                done;
    logic                err;
    logic [3:0][W-1:0]   sideIn;
    logic [3:0][W-1:0]   sideOut;
    logic [3:0]          cornerIn;

    always #5 clk = ~clk;

    switch_block_param #(.TRACK_WIDTH(W)) dut (
        .i_ConfigClock       (clk),
        .i_Reset             (rst),
        .i_ConfigShiftEnable (shEn),
        .i_ConfigShiftInput  (shIn),
        .o_ConfigShiftOutput (shOut),
        .i_ConfigCommit      (commit),
        .o_ConfigDone        (done),
        .o_ConfigError       (err),
        .i_SideInputs        (sideIn),
        .o_SideOutputs       (sideOut),
        .i_CornerInputs      (cornerIn)
    );

    int nVec  = 0;
    int nFail = 0;

    // Reference model: full bit history since reset, saturating count, active codes per mux
    bit allBits[$];
    int mCnt;
    bit mDone;
    bit mErr;
    bit mSo;
    int mAct[4][W];

    function automatic logic [CHAIN-1:0] mShadow();
        logic [CHAIN-1:0] r;
        int n;
        n = allBits.size();
        for (int i = 0; i < CHAIN; i++) r[i] = (n > i) ? allBits[n-1-i] : 1'b0;
        return r;
    endfunction

    function automatic logic [3:0][W-1:0] expOutputs();
        logic [3:0][W-1:0] r;
        int k;
        int m;
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < W; t++) begin
                k = mAct[s][t];
                m = k / 2;
                if (k == 1)          r[s][t] = 1'b0;
                else if (k % 2 == 0) r[s][t] = cornerIn[(s + m) % 4];
                else                 r[s][t] = sideIn[(s + m) % 4][t];
            end
        end
        return r;
    endfunction

    function automatic logic [CFG_BITS-1:0] mkCfg(input int northCode, input int otherCode);
        logic [CFG_BITS-1:0] c;
        for (int f = 0; f < 4 * W; f++) c[f*3 +: 3] = (f < W) ? 3'(northCode) : 3'(otherCode);
        return c;
    endfunction

    task automatic modelReset();
        allBits.delete();
        mCnt  = 0;
        mDone = 1'b0;
        mErr  = 1'b0;
        mSo   = 1'b0;
        for (int s = 0; s < 4; s++) for (int t = 0; t < W; t++) mAct[s][t] = 1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic randIn();
        sideIn   = 16'($urandom);
        cornerIn = 4'($urandom);
    endtask

    task automatic checkState(input string tag, input int toggles);
        check({tag, "_done"}, 64'(done), 64'(mDone));
        check({tag, "_err"},  64'(err),  64'(mErr));
        for (int i = 0; i < toggles; i++) begin
            randIn();
            #1;
            check({tag, "_routes"}, 64'(sideOut), 64'(expOutputs()));
        end
    endtask

    task automatic cycle(input bit sh, input bit din, input bit cm);
        logic [CHAIN-1:0] pre;
        bit               valid;
        logic [CFG_BITS-1:0] f;
        shEn   = sh;
        shIn   = din;
        commit = cm;
        @(posedge clk);
        #1;
        pre = mShadow();
`ifdef SWITCH_BLOCK_CFG_PARITY_EN
        valid = cm && (mCnt == CHAIN) && ((^pre) == 1'b0);
`else
        valid = cm && (mCnt == CHAIN);
`endif
        if (cm) begin
            if (valid) begin
                f = pre[CHAIN-1 -: CFG_BITS];
                for (int s = 0; s < 4; s++)
                    for (int t = 0; t < W; t++) mAct[s][t] = int'(f[(s*W+t)*3 +: 3]);
                mDone = 1'b1;
                mErr  = 1'b0;
                mCnt  = 0;
            end else begin
                mErr = 1'b1;
            end
        end
        if (sh) begin
            allBits.push_back(din);
            if (mCnt < CHAIN) mCnt++;
            mSo = (allBits.size() > CHAIN) ? allBits[allBits.size()-1-CHAIN] : 1'b0;
        end
        shEn   = 1'b0;
        commit = 1'b0;
    endtask

    task automatic loadCfg(input logic [CFG_BITS-1:0] cfg);
        for (int i = CFG_BITS - 1; i >= 0; i--) cycle(1'b1, cfg[i], 1'b0);
`ifdef SWITCH_BLOCK_CFG_PARITY_EN
        cycle(1'b1, ^cfg, 1'b0);
`endif
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        logic [CFG_BITS-1:0] cfg;
        rst = 1'b1; shEn = 1'b0; shIn = 1'b0; commit = 1'b0;
        randIn();
        doReset();

        // Reset state with inputs toggling
        checkState("reset", 4);
        check("reset_shout", 64'(shOut), 64'(0));

        // North tracks take East, everything else tied low
        loadCfg(mkCfg(3, 1));
        check("pre_commit_done", 64'(done), 64'(0));
        cycle(1'b0, 1'b0, 1'b1);
        check("commit_done", 64'(done), 64'(1));
        for (int i = 0; i < 3; i++) begin
            randIn();
            #1;
            check("north_is_east", 64'(sideOut[0]), 64'(sideIn[1]));
            check("others_low", 64'(sideOut[3:1]), 64'(0));
        end
        checkState("north_east", 2);

        // Short load then commit: error, routing unchanged; full load clears it
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'($urandom), 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check("short_err", 64'(err), 64'(1));
        checkState("short_load", 3);
        loadCfg(CFG_BITS'({$urandom, $urandom}));
        cycle(1'b0, 1'b0, 1'b1);
        check("recover_err", 64'(err), 64'(0));
        checkState("recover", 3);

        // Chain pass-through latency
        doReset();
        cycle(1'b1, 1'b1, 1'b0);
        check("so_1", 64'(shOut), 64'(mSo));
        for (int i = 0; i < CHAIN + 1; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            check("shift_out", 64'(shOut), 64'(mSo));
        end

        // Over-shift keeps the most recent bits
        for (int i = 0; i < CHAIN + 12; i++) cycle(1'b1, 1'($urandom), 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        checkState("overshift", 3);

        // Shift and commit together: commit uses the full load, next commit is short
        loadCfg(CFG_BITS'({$urandom, $urandom}));
        cycle(1'b1, 1'b1, 1'b1);
        checkState("shift_commit", 2);
        cycle(1'b0, 1'b0, 1'b1);
        check("after_shift_commit_err", 64'(err), 64'(1));

        // Reset in the middle of a load
        loadCfg(mkCfg(7, 4));
        cycle(1'b0, 1'b0, 1'b1);
        checkState("pre_midreset", 2);
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'($urandom), 1'b0);
        doReset();
        checkState("midreset", 3);
        cycle(1'b0, 1'b0, 1'b1);
        check("midreset_commit_err", 64'(err), 64'(1));
        check("midreset_commit_done", 64'(done), 64'(0));

        // Random configurations covering all mux codes
        for (int r = 0; r < 6; r++) begin
            loadCfg(CFG_BITS'({$urandom, $urandom}));
            cycle(1'b0, 1'b0, 1'b1);
            checkState("random_cfg", 3);
        end

`ifdef SWITCH_BLOCK_CFG_PARITY_EN
        // Corrupt parity bit blocks the commit; a correct one goes through
        cfg = CFG_BITS'({$urandom, $urandom});
        for (int i = CFG_BITS - 1; i >= 0; i--) cycle(1'b1, cfg[i], 1'b0);
        cycle(1'b1, ~(^cfg), 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check("bad_parity_err", 64'(err), 64'(1));
        checkState("bad_parity", 2);
        loadCfg(cfg);
        cycle(1'b0, 1'b0, 1'b1);
        check("good_parity_err", 64'(err), 64'(0));
        checkState("good_parity", 2);
`else
        cfg = mkCfg(2, 5);
        loadCfg(cfg);
        cycle(1'b0, 1'b0, 1'b1);
        checkState("fixed_cfg", 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
